// File: rtl/drp_adc_responder.sv
// drp_adc_responder: responder side of the XADC dynamic reconfiguration port.
// A four-channel auxiliary conversion sequencer stores fabric-supplied samples
// in DRP-addressable result registers. DRP reads and writes are answered with
// a fixed-latency ready strobe.
module drp_adc_responder #(
  parameter int DRP_LATENCY = 4,   // accepted den_in -> drdy_out, 2..15
  parameter int CONV_CYCLES = 26   // cycles per conversion, 4..255
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESET,
  input  logic        den_in,
  input  logic        dwe_in,
  input  logic [6:0]  daddr_in,
  input  logic [15:0] di_in,
  output logic [15:0] do_out,
  output logic        drdy_out,
  output logic        eoc_out,
  output logic [6:0]  channel_out,
  output logic        busy_out,
  input  logic [11:0] vaux6_in,
  input  logic [11:0] vaux7_in,
  input  logic [11:0] vaux14_in,
  input  logic [11:0] vaux15_in
);

  localparam logic [6:0] ADDR_VAUX6  = 7'h16;
  localparam logic [6:0] ADDR_VAUX7  = 7'h17;
  localparam logic [6:0] ADDR_VAUX14 = 7'h1E;
  localparam logic [6:0] ADDR_VAUX15 = 7'h1F;
  localparam logic [6:0] ADDR_CFG    = 7'h40;

  // Counter values at which the end-of-conversion pulse is launched and at
  // which the conversion completes (the eoc_out cycle itself).
  localparam logic [7:0] CNT_EOC  = 8'(CONV_CYCLES - 2);
  localparam logic [7:0] CNT_LAST = 8'(CONV_CYCLES - 1);
  // Latency counter value at which drdy_out is launched.
  localparam logic [3:0] LAT_LAST = 4'(DRP_LATENCY - 1);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_CONVERT = 1'b1
  } state_t;

  // Sequence index 0..3 walks 0x16 -> 0x17 -> 0x1E -> 0x1F and wraps.
  function automatic logic [6:0] ch_addr(input logic [1:0] idx);
    case (idx)
      2'd0:    ch_addr = ADDR_VAUX6;
      2'd1:    ch_addr = ADDR_VAUX7;
      2'd2:    ch_addr = ADDR_VAUX14;
      default: ch_addr = ADDR_VAUX15;
    endcase
  endfunction

  // Sample sources indexed by sequence position.
  logic [3:0][11:0] vaux_vec;
  assign vaux_vec = {vaux15_in, vaux14_in, vaux7_in, vaux6_in};

  // Only bit 0 of the config register has storage.
  logic unused_di_bits;
  assign unused_di_bits = ^di_in[15:1];

  // Sequencer state
  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [11:0]      sample_q, sample_d;
  logic [3:0][15:0] result_q, result_d;
  logic             cfg_en_q, cfg_en_d;
  logic             eoc_q, eoc_d;
  logic [6:0]       chan_q, chan_d;
  logic             busy_q, busy_d;

  // DRP transaction state
  logic             pend_q, pend_d;
  logic [3:0]       lat_q, lat_d;
  logic [15:0]      rdata_q, rdata_d;
  logic [15:0]      do_q, do_d;
  logic             drdy_q, drdy_d;

  logic [15:0]      rd_mux;

  // Next-state logic for the conversion sequencer and the DRP responder.
  always_comb begin
    // NOTE: every signal gets a default before any branch so that no path
    // leaves it unassigned; a missing default here would infer a latch.
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    sample_d = sample_q;
    result_d = result_q;
    cfg_en_d = cfg_en_q;
    eoc_d    = 1'b0;
    chan_d   = 7'h00;
    pend_d   = pend_q;
    lat_d    = lat_q;
    rdata_d  = rdata_q;
    do_d     = 16'h0000;
    drdy_d   = 1'b0;
    rd_mux   = 16'h0000;

    // Sequencer: the decision to continue uses the enable as it stood
    // before this edge, so a disable lets the running conversion finish.
    case (state_q)
      S_IDLE: begin
        if (cfg_en_q) begin
          state_d  = S_CONVERT;
          cnt_d    = 8'd0;
          sample_d = vaux_vec[ptr_q];
        end
      end
      S_CONVERT: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == CNT_EOC) begin
          eoc_d  = 1'b1;
          chan_d = ch_addr(ptr_q);
        end
        if (cnt_q == CNT_LAST) begin
          result_d[ptr_q] = {sample_q, 4'h0};
          ptr_d           = ptr_q + 2'd1;
          cnt_d           = 8'd0;
          if (cfg_en_q) begin
            sample_d = vaux_vec[ptr_q + 2'd1];
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_CONVERT);

    // Register read mux sees pre-edge contents, so a result landing on the
    // accepting edge is not visible to that read.
    case (daddr_in)
      ADDR_VAUX6:  rd_mux = result_q[0];
      ADDR_VAUX7:  rd_mux = result_q[1];
      ADDR_VAUX14: rd_mux = result_q[2];
      ADDR_VAUX15: rd_mux = result_q[3];
      ADDR_CFG:    rd_mux = {15'h0000, cfg_en_q};
      default:     rd_mux = 16'h0000;
    endcase

    // DRP: one transaction at a time; requests while pending (including the
    // drdy_out cycle) are dropped without a response.
    if (pend_q) begin
      if (drdy_q) begin
        pend_d = 1'b0;
      end else if (lat_q == LAT_LAST) begin
        drdy_d = 1'b1;
        do_d   = rdata_q;
      end else begin
        lat_d = lat_q + 4'd1;
      end
    end else if (den_in) begin
      pend_d  = 1'b1;
      lat_d   = 4'd1;
      rdata_d = dwe_in ? 16'h0000 : rd_mux;
      if (dwe_in && (daddr_in == ADDR_CFG)) begin
        cfg_en_d = di_in[0];
      end
    end
  end

  // State registers; reset discards any in-flight transaction or conversion.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      state_q  <= S_IDLE;
      ptr_q    <= 2'd0;
      cnt_q    <= 8'd0;
      sample_q <= 12'h000;
      // NOTE: the result registers are a small register file that is
      // reset on purpose, because reads after reset must return zero.
      result_q <= '0;
      cfg_en_q <= 1'b1;
      eoc_q    <= 1'b0;
      chan_q   <= 7'h00;
      busy_q   <= 1'b0;
      pend_q   <= 1'b0;
      lat_q    <= 4'd0;
      rdata_q  <= 16'h0000;
      do_q     <= 16'h0000;
      drdy_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge
      // values regardless of statement order.
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      sample_q <= sample_d;
      result_q <= result_d;
      cfg_en_q <= cfg_en_d;
      eoc_q    <= eoc_d;
      chan_q   <= chan_d;
      busy_q   <= busy_d;
      pend_q   <= pend_d;
      lat_q    <= lat_d;
      rdata_q  <= rdata_d;
      do_q     <= do_d;
      drdy_q   <= drdy_d;
    end
  end

  assign do_out      = do_q;
  assign drdy_out    = drdy_q;
  assign eoc_out     = eoc_q;
  assign channel_out = chan_q;
  assign busy_out    = busy_q;

endmodule

// File: tb/tb_drp_adc_responder.sv
// Scoreboard bench for drp_adc_responder: stimulus pushes expected DRP
// responses and conversion events (with their due cycle) into queues; a
// monitor on the falling edge pops and compares whatever the DUT presents.
module tb_drp_adc_responder;

  localparam int L  = 4;
  localparam int CC = 26;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } drp_exp_t;

  typedef struct {
    logic [6:0] ch;
    int         cyc;
  } eoc_exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        den_in = 1'b0;
  logic        dwe_in = 1'b0;
  logic [6:0]  daddr_in = 7'h00;
  logic [15:0] di_in = 16'h0000;
  logic [15:0] do_out;
  logic        drdy_out;
  logic        eoc_out;
  logic [6:0]  channel_out;
  logic        busy_out;
  logic [11:0] vaux6_in = 12'h000;
  logic [11:0] vaux7_in = 12'h000;
  logic [11:0] vaux14_in = 12'h000;
  logic [11:0] vaux15_in = 12'h000;

  drp_adc_responder #(.DRP_LATENCY(L), .CONV_CYCLES(CC)) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESET (rst),
    .den_in       (den_in),
    .dwe_in       (dwe_in),
    .daddr_in     (daddr_in),
    .di_in        (di_in),
    .do_out       (do_out),
    .drdy_out     (drdy_out),
    .eoc_out      (eoc_out),
    .channel_out  (channel_out),
    .busy_out     (busy_out),
    .vaux6_in     (vaux6_in),
    .vaux7_in     (vaux7_in),
    .vaux14_in    (vaux14_in),
    .vaux15_in    (vaux15_in)
  );

  always #5 clk = ~clk;

  // Cycle index: 0 in the cycle right after reset release, k after edge k.
  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  int n_checks = 0;
  int n_errors = 0;
  drp_exp_t drp_q[$];
  eoc_exp_t eoc_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  // Monitor: compares every DUT response against the scoreboard heads.
  drp_exp_t de;
  eoc_exp_t ee;
  always @(negedge clk) begin
    if (!rst) begin
      if (drp_q.size() > 0 && drp_q[0].cyc < cyc) begin
        de = drp_q.pop_front();
        check("drdy_missing_cycle", cyc, de.cyc);
      end
      if (drdy_out) begin
        if (drp_q.size() == 0) begin
          check("drdy_unexpected", drdy_out, 1'b0);
        end else begin
          de = drp_q.pop_front();
          check("drdy_cycle", cyc, de.cyc);
          check("do_out", do_out, de.data);
        end
      end else begin
        check("do_out_idle", do_out, 16'h0000);
      end

      if (eoc_q.size() > 0 && eoc_q[0].cyc < cyc) begin
        ee = eoc_q.pop_front();
        check("eoc_missing_cycle", cyc, ee.cyc);
      end
      if (eoc_out) begin
        if (eoc_q.size() == 0) begin
          check("eoc_unexpected", eoc_out, 1'b0);
        end else begin
          ee = eoc_q.pop_front();
          check("eoc_cycle", cyc, ee.cyc);
          check("channel_out", channel_out, ee.ch);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) idle(1);
  endtask

  // One-cycle DRP request; if a response is expected it is due L cycles later.
  task automatic drp(input logic we, input logic [6:0] a, input logic [15:0] d,
                     input logic expect_resp, input logic [15:0] exp_data);
    den_in   = 1'b1;
    dwe_in   = we;
    daddr_in = a;
    di_in    = d;
    if (expect_resp) drp_q.push_back('{data: exp_data, cyc: cyc + L});
    idle(1);
    den_in   = 1'b0;
    dwe_in   = 1'b0;
    daddr_in = 7'h00;
    di_in    = 16'h0000;
  endtask

  task automatic rd(input logic [6:0] a, input logic [15:0] exp_data);
    drp(1'b0, a, 16'h0000, 1'b1, exp_data);
    idle(L);
  endtask

  task automatic wr(input logic [6:0] a, input logic [15:0] d);
    drp(1'b1, a, d, 1'b1, 16'h0000);
    idle(L);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_do_out"}, do_out, 16'h0000);
    check({tag, "_drdy_out"}, drdy_out, 1'b0);
    check({tag, "_eoc_out"}, eoc_out, 1'b0);
    check({tag, "_channel_out"}, channel_out, 7'h00);
    check({tag, "_busy_out"}, busy_out, 1'b0);
  endtask

  initial begin
    vaux6_in  = 12'hABC;
    vaux7_in  = 12'h123;
    vaux14_in = 12'hFFF;
    vaux15_in = 12'h000;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;

    // Free-running sequence from reset release.
    eoc_q.push_back('{ch: 7'h16, cyc: 26});
    eoc_q.push_back('{ch: 7'h17, cyc: 52});
    eoc_q.push_back('{ch: 7'h1E, cyc: 78});
    eoc_q.push_back('{ch: 7'h1F, cyc: 104});
    eoc_q.push_back('{ch: 7'h16, cyc: 130});
    eoc_q.push_back('{ch: 7'h17, cyc: 156});
    rd(7'h40, 16'h0001);
    rd(7'h16, 16'h0000);
    check("busy_first_conv", busy_out, 1'b1);

    wait_cyc(106);
    rd(7'h16, 16'hABC0);
    rd(7'h17, 16'h1230);
    rd(7'h1E, 16'hFFF0);
    rd(7'h1F, 16'h0000);

    // Requests while pending (and on the drdy cycle) get no response.
    vaux7_in = 12'h555;
    drp(1'b0, 7'h16, 16'h0000, 1'b1, 16'hABC0);  // cyc 126 -> drdy 130
    idle(1);
    drp(1'b0, 7'h1E, 16'h0000, 1'b0, 16'h0000);  // cyc 128, ignored
    idle(1);
    drp(1'b0, 7'h1F, 16'h0000, 1'b0, 16'h0000);  // cyc 130, drdy cycle, ignored
    drp(1'b0, 7'h17, 16'h0000, 1'b1, 16'h1230);  // cyc 131 -> drdy 135
    idle(L);

    wait_cyc(140);
    check("busy_running", busy_out, 1'b1);

    // Read accepted on the edge that completes the 0x17 conversion.
    wait_cyc(156);
    rd(7'h17, 16'h1230);
    rd(7'h17, 16'h5550);

    // Disable during the 0x1E conversion; it still finishes.
    wait_cyc(170);
    eoc_q.push_back('{ch: 7'h1E, cyc: 182});
    wr(7'h40, 16'h0000);
    check("busy_draining", busy_out, 1'b1);
    wait_cyc(184);
    check("busy_after_disable", busy_out, 1'b0);

    // Re-enable resumes at 0x1F.
    wait_cyc(200);
    eoc_q.push_back('{ch: 7'h1F, cyc: 227});
    eoc_q.push_back('{ch: 7'h16, cyc: 253});
    wr(7'h40, 16'h0001);
    wait_cyc(215);
    check("busy_resumed", busy_out, 1'b1);

    // Register map edges.
    wait_cyc(228);
    rd(7'h40, 16'h0001);
    rd(7'h00, 16'h0000);
    rd(7'h7F, 16'h0000);
    wr(7'h16, 16'hFFFF);
    rd(7'h16, 16'hABC0);

    // Reset during a pending read and a running conversion.
    wait_cyc(258);
    vaux6_in = 12'h321;
    drp(1'b0, 7'h16, 16'h0000, 1'b0, 16'h0000);
    idle(1);
    check("busy_before_reset", busy_out, 1'b1);
    rst = 1'b1;
    #2;
    check_outputs_zero("async_reset");
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("held_reset");
    rst = 1'b0;

    // Sequence restarts at 0x16 with cleared results.
    eoc_q.push_back('{ch: 7'h16, cyc: 26});
    rd(7'h16, 16'h0000);
    rd(7'h17, 16'h0000);
    rd(7'h1E, 16'h0000);
    rd(7'h40, 16'h0001);
    wait_cyc(27);
    rd(7'h16, 16'h3210);

    wait_cyc(40);
    check("drp_queue_drained", drp_q.size(), 0);
    check("eoc_queue_drained", eoc_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/drp_adc_responder.md
# drp_adc_responder

Responder end of the XADC dynamic reconfiguration port (DRP). It runs an auxiliary-channel conversion sequencer over four channels, stores each result in a DRP-addressable register, and pulses end-of-conversion. It answers DRP reads and writes with a fixed-latency ready strobe. It stands in for the XADC primitive behind the pot/LED user logic, so that logic and its AXI register path can run on fabric-supplied samples in simulation and in bring-up builds.

## Interface
- DRP_LATENCY, default 4: cycles from accepted `den_in` to the `drdy_out` pulse; legal range 2..15.
- CONV_CYCLES, default 26: cycles per conversion; legal range 4..255.
- S_AXI_ACLK  in  1  clock.
- S_AXI_ARESET  in  1  reset, asynchronous and active-high.
- den_in  in  1  DRP enable; one-cycle request strobe.
- dwe_in  in  1  DRP write enable; sampled with `den_in`.
- daddr_in  in  7  DRP register address.
- di_in  in  16  DRP write data.
- do_out  out  16  DRP read data; valid only while `drdy_out` is high.
- drdy_out  out  1  DRP ready; one-cycle pulse.
- eoc_out  out  1  end-of-conversion; one-cycle pulse.
- channel_out  out  7  DRP address of the channel just converted; valid with `eoc_out`.
- busy_out  out  1  high while a conversion is in progress.
- vaux6_in, vaux7_in, vaux14_in, vaux15_in  in  12 each  unsigned sample sources.

## Operation
- Register map:
  - 0x16 holds the vaux6 result; 0x17 vaux7; 0x1E vaux14; 0x1F vaux15.
  - Each result register is 16 bits: sample in [15:4], [3:0] = 0.
  - 0x40 is the config register. Bit 0 = sequencer enable, reset value 1. Bits [15:1] read 0.
  - Any other address reads 0x0000. Writes to any address other than 0x40 are ignored but still acknowledged.
- Sequencer states: IDLE, CONVERT.
  - IDLE → CONVERT when enable = 1. The current sequence channel's input is captured on entry. The conversion counter loads 0.
  - In CONVERT the counter increments each cycle.
  - At count CONV_CYCLES-1:
    - the captured sample is written to the channel's result register;
    - `eoc_out` = 1 and `channel_out` = the channel address for that cycle;
    - the sequence pointer advances through 0x16 → 0x17 → 0x1E → 0x1F → 0x16;
    - if enable = 1 the state goes to CONVERT with the next channel, back to back; otherwise it goes to IDLE.
  - `busy_out` = 1 exactly while in CONVERT.
  - Clearing enable mid-conversion lets that conversion finish; the sequence then stops.
  - Re-enabling resumes at the next channel in sequence, not at 0x16.
- DRP handshake:
  - A `den_in` is accepted only when no transaction is pending.
  - Address, `dwe_in` and `di_in` are latched on the accepting cycle.
  - Read data is the register content before that clock edge. A result update on the same edge is not visible to that read.
  - A write to 0x40 takes effect at the accepting edge.
  - `den_in` while a transaction is pending, including the `drdy_out` cycle, is ignored and produces no response.
  - Write acknowledgements return `do_out` = 0x0000.
- `do_out` = 0x0000 whenever `drdy_out` = 0.
- Reset values:
  - `do_out` = 0, `drdy_out` = 0, `eoc_out` = 0, `channel_out` = 0, `busy_out` = 0.
  - All result registers = 0; config = 0x0001.
  - Sequence pointer = 0x16; state = IDLE; no pending transaction.
- Reset asserted mid-transaction or mid-conversion discards the transaction or conversion immediately. No `drdy_out` or `eoc_out` is produced for it.

## Timing
- `den_in` accepted at edge T → `drdy_out` high for exactly the cycle after edge T+DRP_LATENCY-1, i.e. DRP_LATENCY cycles after the request.
- Next `den_in` is accepted no earlier than the cycle after the `drdy_out` cycle. Maximum throughput is one transaction per DRP_LATENCY+1 cycles.
- First conversion after reset release:
  - starts at the first clock edge, entering CONVERT;
  - its `eoc_out` is high in the cycle after CONV_CYCLES edges.
- Conversion period is CONV_CYCLES cycles. Successive `eoc_out` pulses are exactly CONV_CYCLES apart while enabled.
- The result register is readable with the new value from the cycle after `eoc_out`.
- `eoc_out` and `drdy_out` are independent and may assert in the same cycle.

## Test plan
- Reset, then hold vaux6/7/14/15 = 0xABC/0x123/0xFFF/0x000 → `eoc_out` pulses every 26 cycles. `channel_out` sequence is 0x16, 0x17, 0x1E, 0x1F, 0x16. Reads afterwards return 0xABC0, 0x1230, 0xFFF0, 0x0000.
- Read 0x16 via `den_in` at cycle T → `drdy_out` only at T+4 with `do_out` = register value. A second `den_in` at T+2 and at T+4 gets no response. `den_in` at T+5 is answered at T+9.
- Issue `den_in` reading 0x17 on the same edge that 0x17 conversion completes with new sample 0x555 → returns the old value. An immediate re-read returns 0x5550.
- Write 0x0000 to 0x40 mid-conversion of 0x1E:
  - write acknowledged with `do_out` = 0;
  - the 0x1E conversion still finishes with `eoc_out`, then `busy_out` = 0 and no further `eoc_out`;
  - write 0x0001 → next `eoc_out` has `channel_out` = 0x1F.
- Read 0x40 → 0x0001 after reset. Read 0x00 and 0x7F → 0x0000. Write 0xFFFF to 0x16 → acknowledged, and 0x16 is unchanged.
- Assert S_AXI_ARESET two cycles after a read `den_in` and mid-conversion → no `drdy_out` or `eoc_out` follows, all outputs 0 asynchronously, results cleared. The sequence restarts at 0x16 after release.
